sram_access_arbiter: RTL
========================

// Module: sram_access_arbiter
// PURPOSE
//  Shares one 1R1W sram instance between NUM_CLIENTS requesters, e.g. the state-vector engine and the host loader.
//  - Independent round-robin arbitration of the read and write ports.
//  - Enforces RAW safety: the sram returns X for a read of an address written at the same or previous edge.
//  - Returns read data with client id. Sits between the compute datapath and every sram instance.
// PARAMETERS
//  NUM_CLIENTS  2   number of requesters (>=2); CID_W = $clog2(NUM_CLIENTS) localparam
//  ADDR_WIDTH   32  sram address width
//  DATA_WIDTH   16  sram data width
// PORTS
//  clk                 in   1            clock; all logic on posedge
//  reset_n             in   1            asynchronous, active-low reset
//  rd_req_valid        in   NUM_CLIENTS  per-client read request
//  rd_req_addr         in   N*ADDR_WIDTH packed read addresses, client i at [i*AW +: AW]
//  rd_req_ready        out  NUM_CLIENTS  read grant; transfer on valid&ready at posedge
//  wr_req_valid        in   NUM_CLIENTS  per-client write request
//  wr_req_addr         in   N*ADDR_WIDTH packed write addresses
//  wr_req_data         in   N*DATA_WIDTH packed write data
//  wr_req_ready        out  NUM_CLIENTS  write grant
//  rd_rsp_valid        out  1            read response valid (one cycle)
//  rd_rsp_client       out  CID_W        client id of response
//  rd_rsp_data         out  DATA_WIDTH   read data
//  rd_stall_cnt        out  16           saturating count of hazard-blocked read cycles
//  sram_write_address  out  ADDR_WIDTH   to sram write_address
//  sram_write_data     out  DATA_WIDTH   to sram write_data
//  sram_write_enable   out  1            to sram write_enable; never X/Z
//  sram_read_address   out  ADDR_WIDTH   to sram read_address
//  sram_read_data      in   DATA_WIDTH   from sram read_data
// BEHAVIOUR
//  - Reset: all ready=0, rd_rsp_valid=0, rd_stall_cnt=0, RR pointers->client 0, last-write and hold state cleared.
//  - sram_write_enable forced 0 while reset_n low (X/Z would wipe the sram). Reset mid-op drops granted reads: no response.
//  - Grants are combinational from valid + state. At most one write grant and one read grant per cycle.
//  - sram_write_* and sram_read_address are driven from the granted client. They are 0 when nothing is granted.
//  - Write arbiter: RR among valid writes; pointer moves past the granted client; idle keeps pointer.
//  - Hazard: a read is ineligible if its addr == current granted write addr, or == last-cycle write addr with last_wr_en=1.
//  - Read arbiter: RR among valid, eligible reads; blocked clients are skipped without losing RR position.
//  - Hold: once a read is blocked, writes to that address are masked from the write arbiter.
//    The hold is kept until that read is granted, so its total stall is <=2 cycles.
//  - Ordering: a same-cycle write wins; the read observes the newly written data.
//  - Latency: read granted at edge E; rd_rsp_valid/client registered at E; rd_rsp_data = sram_read_data in cycle E+1.
//  - Back-to-back reads give back-to-back responses; no backpressure on responses.
//  - rd_stall_cnt: +1 per cycle in which any valid read is hazard-blocked; saturates at 16'hFFFF.
//  - Unwritten addresses return whatever the sram returns (X); the arbiter does not mask this.
// CONFIGURATION
//  SRAM_ARB_FWD_EN defined:
//    - Hazard reads are eligible and never stall.
//    - A forwarding register captures the matching write data at E.
//    - rd_rsp_data in E+1 = forwarded data, not sram_read_data; the hold mask is unused; rd_stall_cnt stays 0.
//  Not defined: stall/hold scheme above; no forwarding logic is built.
// STRUCTURE
//  - sram_arb_pkg: typedef cid_t, rd_req_t {addr}, wr_req_t {addr,data}, rd_rsp_t {cid,data}; STALL_CNT_W = 16.
//  - Sub-module rr_arbiter #(N): request vector + eligibility mask in, one-hot grant out, registered pointer.
//    It is instantiated twice: read and write.
// TESTING
//  1 reset_n=0 with random requests -> ready=0, rd_rsp_valid=0, sram_write_enable=0 (never X), rd_stall_cnt=0.
//  2 preload 0x10=AAAA,0x20=BBBB; c0 reads 0x10, c1 reads 0x20 together -> c0 then c1 granted;
//    responses (0,AAAA) then (1,BBBB) in consecutive cycles.
//  3 c0 writes 0x40=1234 while c1 reads 0x40 -> no FWD: read granted 2 cycles later, data 1234, stall_cnt=2;
//    FWD: granted same cycle, data 1234 next cycle, stall_cnt=0.
//  4 both clients write continuously 8 cycles -> grants alternate c0,c1; 4 writes each in the sram.
//  5 c1 reads 0x50 while c0 writes 0x50 every cycle -> c0 masked after first write; read granted within 2 cycles.
//  6 assert reset_n the cycle after a read grant -> rd_rsp_valid drops immediately; no response after release.

Source files
------------

// File: rtl/sram_access_arbiter_pkg.sv
// sram_arb_pkg: shared types, widths and the saturating stall-counter helper for the sram access arbiter
package sram_arb_pkg;
  localparam int DEF_CLIENTS = 2;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 16;
  localparam int STALL_CNT_W = 16;
  typedef logic [$clog2(DEF_CLIENTS)-1:0] cid_t;
  typedef struct packed {
    logic [DEF_AW-1:0] addr;
  } rd_req_t;
  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } wr_req_t;
  typedef struct packed {
    cid_t              cid;
    logic [DEF_DW-1:0] data;
  } rd_rsp_t;
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sram_access_arbiter_rr.sv
// rr_arbiter: round-robin pick among eligible requests with a registered priority pointer
//   clk, reset_n : clock, asynchronous active-low reset (pointer -> client 0)
//   req          : request vector
//   elig         : eligibility mask, a request only competes where its bit is set
//   grant        : one-hot grant (combinational); pointer moves past the winner, idle keeps it
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] elig,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [N-1:0] eff, hi;
  assign eff = req & elig;
  // requests at or above the pointer win first; otherwise wrap to the lowest index
  assign hi = eff & ~((N'(1) << ptr) - N'(1));
  assign grant = |hi ? hi & (~hi + N'(1)) : eff & (~eff + N'(1));
  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < N; i++) if (grant[i]) ptr_nxt = PW'((i + 1) % N);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else ptr <= ptr_nxt;
endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one 1R1W sram between NUM_CLIENTS requesters with RAW-safe read arbitration
//   clk, reset_n                           : clock, asynchronous active-low reset
//   rd_req_valid/addr, rd_req_ready         : per-client read requests and grants
//   wr_req_valid/addr/data, wr_req_ready    : per-client write requests and grants
//   rd_rsp_valid/client/data                : read response, valid the cycle after the grant
//   rd_stall_cnt                            : saturating count of cycles with a hazard-blocked read
//   sram_write_*, sram_read_address/data    : sram interface, driven from the granted clients
//   SRAM_ARB_FWD_EN: forward write data to hazard reads instead of stalling them
module sram_access_arbiter import sram_arb_pkg::*; #(
  parameter int NUM_CLIENTS = DEF_CLIENTS,
  parameter int ADDR_WIDTH = DEF_AW,
  parameter int DATA_WIDTH = DEF_DW,
  localparam int CID_W = $clog2(NUM_CLIENTS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_CLIENTS-1:0]            rd_req_valid,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_req_addr,
  output logic [NUM_CLIENTS-1:0]            rd_req_ready,
  input  logic [NUM_CLIENTS-1:0]            wr_req_valid,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_req_data,
  output logic [NUM_CLIENTS-1:0]            wr_req_ready,
  output logic                              rd_rsp_valid,
  output logic [CID_W-1:0]                  rd_rsp_client,
  output logic [DATA_WIDTH-1:0]             rd_rsp_data,
  output logic [STALL_CNT_W-1:0]            rd_stall_cnt,
  output logic [ADDR_WIDTH-1:0]             sram_write_address,
  output logic [DATA_WIDTH-1:0]             sram_write_data,
  output logic                              sram_write_enable,
  output logic [ADDR_WIDTH-1:0]             sram_read_address,
  input  logic [DATA_WIDTH-1:0]             sram_read_data
);
  logic [NUM_CLIENTS-1:0] rd_act, wr_act, rd_elig, wr_elig, rd_gnt, wr_gnt, rd_blk;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic last_en;
  logic [CID_W-1:0] rd_cid;
  // requests are gated by reset so nothing is granted and the sram is never written while reset_n is low
  assign rd_act = rd_req_valid & {NUM_CLIENTS{reset_n}};
  assign wr_act = wr_req_valid & {NUM_CLIENTS{reset_n}};
  rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (.clk, .reset_n, .req(wr_act), .elig(wr_elig), .grant(wr_gnt));
  rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (.clk, .reset_n, .req(rd_act), .elig(rd_elig), .grant(rd_gnt));
  assign rd_req_ready = rd_gnt;
  assign wr_req_ready = wr_gnt;
  assign sram_write_enable = reset_n & |wr_gnt;
  always_comb begin
    sram_write_address = '0;
    sram_write_data = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (wr_gnt[i]) begin
        sram_write_address = wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sram_write_data = wr_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  always_comb begin
    sram_read_address = '0;
    rd_cid = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (rd_gnt[i]) begin
        sram_read_address = rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        rd_cid = CID_W'(i);
      end
  end
  // a read collides with the write granted now or the write committed at the previous edge
  always_comb begin
    rd_blk = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      rd_blk[i] = rd_act[i] &&
        ((sram_write_enable && rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == sram_write_address) ||
         (last_en && rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == last_addr));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_en <= 1'b0;
      last_addr <= '0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_client <= '0;
    end else begin
      last_en <= sram_write_enable;
      last_addr <= sram_write_address;
      rd_rsp_valid <= |rd_gnt;
      rd_rsp_client <= rd_cid;
    end
`ifdef SRAM_ARB_FWD_EN
  logic [DATA_WIDTH-1:0] last_data, fwd_data;
  logic fwd_v;
  assign rd_elig = '1;
  assign wr_elig = '1;
  assign rd_stall_cnt = '0;
  assign rd_rsp_data = fwd_v ? fwd_data : sram_read_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_data <= '0;
      fwd_v <= 1'b0;
      fwd_data <= '0;
    end else begin
      last_data <= sram_write_data;
      fwd_v <= |(rd_gnt & rd_blk);
      // the same-cycle write is newer than the previous-edge write
      fwd_data <= (sram_write_enable && sram_read_address == sram_write_address) ? sram_write_data : last_data;
    end
`else
  logic [NUM_CLIENTS-1:0] hold_v;
  logic [ADDR_WIDTH-1:0] hold_addr [NUM_CLIENTS];
  logic [STALL_CNT_W-1:0] stall_q;
  assign rd_elig = ~rd_blk;
  assign rd_stall_cnt = stall_q;
  assign rd_rsp_data = sram_read_data;
  // writes to an address a blocked read waits on are held off, bounding that read's stall
  always_comb begin
    wr_elig = '1;
    for (int i = 0; i < NUM_CLIENTS; i++)
      for (int j = 0; j < NUM_CLIENTS; j++)
        if (hold_v[j] && wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == hold_addr[j]) wr_elig[i] = 1'b0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hold_v <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) hold_addr[i] <= '0;
      stall_q <= '0;
    end else begin
      hold_v <= rd_act & ~rd_gnt & (rd_blk | hold_v);
      for (int i = 0; i < NUM_CLIENTS; i++)
        if (rd_blk[i]) hold_addr[i] <= rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (|rd_blk) stall_q <= sat_inc(stall_q);
    end
`endif
endmodule
